decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the MIPS32 pipeline. It sits between the IF/ID latch and the EX stage and drives the register file's two combinational read ports. It resolves operands by bypassing from the MEM and WB stages; WB bypass is required because register-file writes land only at the clock edge. It detects RAW hazards that bypass cannot cover, stalls IF, and registers the ID/EX pipeline latch.

## Interface
Parameters: none (MIPS32 widths fixed).
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  IF/ID latch holds a real instruction
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- flush  in  1  kill the instruction in ID (branch/jump redirect)
- id_stall  out  1  IF must hold if_* unchanged next cycle
- rf_addr_1 / rf_addr_2  out  5  register-file read addresses (rs / rt)
- rf_data_1 / rf_data_2  in  32  register-file read data, combinational
- mem_valid, mem_reg_write, mem_mem_read  in  1 each  MEM-stage status
- mem_dest  in  5; mem_data  in  32  MEM-stage destination and ALU result
- wb_valid, wb_reg_write  in  1 each; wb_dest  in  5; wb_data  in  32  WB-stage write (same value presented to register file)
- ex_valid, ex_reg_write, ex_mem_read  out  1 each  ID/EX latch status
- ex_pc, ex_instr, ex_rs_val, ex_rt_val, ex_imm  out  32 each  ID/EX latch data
- ex_dest  out  5  ID/EX destination register

## Operation
- Fields: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11]. rf_addr_1=rs, rf_addr_2=rt, always driven from if_instr.
- uses_rs: op not in {0x02 J, 0x03 JAL, 0x0F LUI}.
- uses_rt: op==0x00, or op in {0x04 BEQ, 0x05 BNE, 0x2B SW}.
- Destination selection:
  - op==0x00 → rd.
  - op==0x03 → 31.
  - op in 0x08–0x0F or 0x23 → rt.
  - Otherwise no write.
- reg_write = writes && dest!=0.
- mem_read = (op==0x23).
- imm = sign-extend instr[15:0].
- Operand resolution, per source register r, in priority order:
  1. r==0 → 0.
  2. MEM match (mem_valid && mem_reg_write && mem_dest==r) → mem_data.
  3. WB match → wb_data.
  4. Otherwise rf_data.
- hazard_ex: ex_valid && ex_reg_write && ex_dest!=0 && ex_dest equals a used source.
- hazard_mem: mem_valid && mem_reg_write && mem_mem_read && mem_dest!=0 && mem_dest equals a used source.
- id_stall = if_valid && !flush && (hazard_ex || hazard_mem).
- Latch update on every posedge:
  - Advance (if_valid && !flush && !id_stall): load decoded fields, with ex_valid=1.
  - Otherwise: load a bubble. All ex_* outputs are 0.
- Cost of a consumer directly following its producer:
  - ALU-use: 1 bubble.
  - Load-use: 2 bubbles. The value is bypassed from WB on the third cycle.

## Timing
- Reset (asynchronous, immediate): all ex_* outputs are 0. id_stall and rf_addr_* are combinational and follow the inputs.
- Latency: one cycle from ID to valid ID/EX outputs.
- Stall, flush and bypass paths are combinational within the cycle.
- flush has priority over stall: id_stall=0 and a bubble is latched.
- Stall and forwarding only consider used sources.
- rst asserted mid-stall clears the latch. The instruction held by IF is re-decoded after rst deasserts.
- Simultaneous MEM and WB matches on the same register: MEM wins.

## Test plan
- Reset: assert rst mid-cycle → all ex_* outputs 0 before the next edge. Release rst, present if_valid=1 with ADDI $1,$0,5 (0x20010005) → next edge: ex_valid=1, ex_dest=1, ex_imm=5, ex_reg_write=1.
- WB bypass: wb writes $3=0xDEADBEEF while rf_data_1=0 and ID holds ADD $4,$3,$0 → ex_rs_val=0xDEADBEEF, no stall.
- ALU-use: ADD $2,$1,$1 followed by SUB $5,$2,$1 → id_stall=1 for exactly 1 cycle and one bubble latched. The next cycle forwards mem_data into ex_rs_val.
- Load-use: LW $2,0($1) followed by ADD $3,$2,$2 → id_stall=1 for 2 cycles. ADD then issues with ex_rs_val = ex_rt_val = wb_data.
- Priority and $0:
  - MEM and WB both target $7 with 0x11 and 0x22 → ex_rs_val=0x11.
  - Instruction reading $0 while mem_dest=0 → operand 0, no stall.
- Flush during stall: hazard present and flush=1 → id_stall=0, ex_valid=0 on the next edge.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: MIPS32 instruction-decode stage with MEM/WB operand bypass,
// RAW hazard detection that stalls IF, and the registered ID/EX pipeline latch.
// Latency: one cycle from a decoded IF/ID instruction to valid ex_* outputs.
// Backpressure: id_stall asks IF to hold; a bubble is latched while stalled or flushed.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   if_valid/if_instr/if_pc    IF/ID latch contents
//   flush                      kill the instruction in ID (redirect)
//   id_stall                   IF must hold if_* next cycle
//   rf_addr_1/2, rf_data_1/2   register-file read ports (rs/rt), combinational data
//   mem_*                      MEM-stage status, destination and ALU result
//   wb_*                       WB-stage write (same value being written to the RF)
//   ex_*                       ID/EX latch outputs

module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    output logic        id_stall,
    output logic [4:0]  rf_addr_1,
    output logic [4:0]  rf_addr_2,
    input  logic [31:0] rf_data_1,
    input  logic [31:0] rf_data_2,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_data,
    input  logic        wb_valid,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_instr,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_dest
);

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic        w_uses_rs;
    logic        w_uses_rt;
    logic        w_writes;
    logic [4:0]  w_dest;
    logic        w_reg_write;
    logic        w_mem_read;
    logic [31:0] w_imm;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_haz_ex;
    logic        w_haz_mem;
    logic        w_advance;

    logic        r_valid;
    logic        r_reg_write;
    logic        r_mem_read;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_rs_val;
    logic [31:0] r_rt_val;
    logic [31:0] r_imm;
    logic [4:0]  r_dest;

    assign w_op = if_instr[31:26];
    assign w_rs = if_instr[25:21];
    assign w_rt = if_instr[20:16];
    assign w_rd = if_instr[15:11];

    assign rf_addr_1 = w_rs;
    assign rf_addr_2 = w_rt;

    // Opcode classification: which sources are read and where the result goes.
    always_comb begin
        w_uses_rs = 1'b1;
        w_uses_rt = 1'b0;
        w_writes  = 1'b0;
        w_dest    = 5'd0;
        case (w_op)
            6'h00: begin
                w_uses_rt = 1'b1;
                w_writes  = 1'b1;
                w_dest    = w_rd;
            end
            6'h02: w_uses_rs = 1'b0;
            6'h03: begin
                w_uses_rs = 1'b0;
                w_writes  = 1'b1;
                w_dest    = 5'd31;
            end
            6'h04, 6'h05, 6'h2B: w_uses_rt = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23: begin
                w_writes = 1'b1;
                w_dest   = w_rt;
            end
            6'h0F: begin
                w_uses_rs = 1'b0;
                w_writes  = 1'b1;
                w_dest    = w_rt;
            end
            default: ;
        endcase
    end

    assign w_reg_write = w_writes && (w_dest != 5'd0);
    assign w_mem_read  = (w_op == 6'h23);
    assign w_imm       = {{16{if_instr[15]}}, if_instr[15:0]};

    // Operand resolution: $0 is hard zero, then the younger MEM result beats WB,
    // which beats the register file (its write only lands at the clock edge).
    // Sources the instruction does not read pass the raw register-file value.
    always_comb begin
        w_rs_val = rf_data_1;
        if (w_uses_rs) begin
            if (w_rs == 5'd0)
                w_rs_val = 32'd0;
            else if (mem_valid && mem_reg_write && mem_dest == w_rs)
                w_rs_val = mem_data;
            else if (wb_valid && wb_reg_write && wb_dest == w_rs)
                w_rs_val = wb_data;
        end
    end

    always_comb begin
        w_rt_val = rf_data_2;
        if (w_uses_rt) begin
            if (w_rt == 5'd0)
                w_rt_val = 32'd0;
            else if (mem_valid && mem_reg_write && mem_dest == w_rt)
                w_rt_val = mem_data;
            else if (wb_valid && wb_reg_write && wb_dest == w_rt)
                w_rt_val = wb_data;
        end
    end

    // A producer still in EX has no result yet; a load in MEM has no data until WB.
    assign w_haz_ex = r_valid && r_reg_write && (r_dest != 5'd0) &&
                      ((w_uses_rs && r_dest == w_rs) || (w_uses_rt && r_dest == w_rt));
    assign w_haz_mem = mem_valid && mem_reg_write && mem_mem_read && (mem_dest != 5'd0) &&
                       ((w_uses_rs && mem_dest == w_rs) || (w_uses_rt && mem_dest == w_rt));

    // flush wins over stall: the killed instruction must not hold IF.
    assign id_stall  = if_valid && !flush && (w_haz_ex || w_haz_mem);
    assign w_advance = if_valid && !flush && !id_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_pc        <= 32'd0;
            r_instr     <= 32'd0;
            r_rs_val    <= 32'd0;
            r_rt_val    <= 32'd0;
            r_imm       <= 32'd0;
            r_dest      <= 5'd0;
        end else if (w_advance) begin
            r_valid     <= 1'b1;
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_mem_read;
            r_pc        <= if_pc;
            r_instr     <= if_instr;
            r_rs_val    <= w_rs_val;
            r_rt_val    <= w_rt_val;
            r_imm       <= w_imm;
            r_dest      <= w_dest;
        end else begin
            // Bubble: every latch field is zeroed, not just the valid bit.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_pc        <= 32'd0;
            r_instr     <= 32'd0;
            r_rs_val    <= 32'd0;
            r_rt_val    <= 32'd0;
            r_imm       <= 32'd0;
            r_dest      <= 5'd0;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_reg_write = r_reg_write;
    assign ex_mem_read  = r_mem_read;
    assign ex_pc        = r_pc;
    assign ex_instr     = r_instr;
    assign ex_rs_val    = r_rs_val;
    assign ex_rt_val    = r_rt_val;
    assign ex_imm       = r_imm;
    assign ex_dest      = r_dest;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus a randomized run against a
// behavioural model of the decode rules and the ID/EX latch.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        id_stall;
    logic [4:0]  rf_addr_1, rf_addr_2;
    logic [31:0] rf_data_1, rf_data_2;
    logic        mem_valid, mem_reg_write, mem_mem_read;
    logic [4:0]  mem_dest;
    logic [31:0] mem_data;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        ex_valid, ex_reg_write, ex_mem_read;
    logic [31:0] ex_pc, ex_instr, ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_dest;

    int checks = 0;
    int failures = 0;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .id_stall(id_stall),
        .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2),
        .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_dest(mem_dest), .mem_data(mem_data),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
        .ex_imm(ex_imm), .ex_dest(ex_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [167:0] ex_all();
        return {ex_valid, ex_reg_write, ex_mem_read, ex_pc, ex_instr,
                ex_rs_val, ex_rt_val, ex_imm, ex_dest};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        if_valid = 0; if_instr = 0; if_pc = 0; flush = 0;
        rf_data_1 = 0; rf_data_2 = 0;
        mem_valid = 0; mem_reg_write = 0; mem_mem_read = 0; mem_dest = 0; mem_data = 0;
        wb_valid = 0; wb_reg_write = 0; wb_dest = 0; wb_data = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1;
        tick(); tick();
        checks++; if (ex_all() !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", ex_all()); end
        rst = 0;
        if_valid = 1; if_instr = 32'h20010005; if_pc = 32'h100;
        #1;
        checks++; if ({id_stall, rf_addr_1, rf_addr_2} !== {1'b0, 5'd0, 5'd1}) begin failures++; $display("FAIL addi_comb got=%h exp=%h", {id_stall, rf_addr_1, rf_addr_2}, {1'b0, 5'd0, 5'd1}); end
        tick();
        checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_dest} !== {3'b110, 5'd1}) begin failures++; $display("FAIL addi_ctl got=%h exp=%h", {ex_valid, ex_reg_write, ex_mem_read, ex_dest}, {3'b110, 5'd1}); end
        checks++; if ({ex_imm, ex_pc, ex_rs_val} !== {32'd5, 32'h100, 32'd0}) begin failures++; $display("FAIL addi_data got=%h exp=%h", {ex_imm, ex_pc, ex_rs_val}, {32'd5, 32'h100, 32'd0}); end
        #3 rst = 1;
        #1;
        checks++; if (ex_all() !== '0) begin failures++; $display("FAIL reset_async got=%h exp=0", ex_all()); end
        tick();
        rst = 0;
        set_idle();
        tick();
    endtask

    task automatic test_wb_bypass();
        set_idle();
        if_valid = 1; if_instr = r_type(5'd3, 5'd0, 5'd4, 6'h20); if_pc = 32'h200;
        rf_data_1 = 0; rf_data_2 = 32'h55;
        wb_valid = 1; wb_reg_write = 1; wb_dest = 3; wb_data = 32'hDEADBEEF;
        #1;
        checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL wb_bypass_stall got=%b exp=0", id_stall); end
        tick();
        checks++; if ({ex_valid, ex_dest, ex_rs_val, ex_rt_val} !== {1'b1, 5'd4, 32'hDEADBEEF, 32'd0}) begin failures++; $display("FAIL wb_bypass_val got=%h exp=%h", {ex_valid, ex_dest, ex_rs_val, ex_rt_val}, {1'b1, 5'd4, 32'hDEADBEEF, 32'd0}); end
        set_idle();
        tick();
    endtask

    task automatic test_alu_use();
        set_idle();
        if_valid = 1; if_instr = r_type(5'd1, 5'd1, 5'd2, 6'h20); if_pc = 32'h300;
        rf_data_1 = 7; rf_data_2 = 7;
        tick();
        checks++; if ({ex_valid, ex_reg_write, ex_dest} !== {2'b11, 5'd2}) begin failures++; $display("FAIL alu_prod got=%h exp=%h", {ex_valid, ex_reg_write, ex_dest}, {2'b11, 5'd2}); end
        if_instr = r_type(5'd2, 5'd1, 5'd5, 6'h22); if_pc = 32'h304;
        rf_data_1 = 32'hBAD; rf_data_2 = 7;
        #1;
        checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL alu_stall1 got=%b exp=1", id_stall); end
        tick();
        checks++; if (ex_all() !== '0) begin failures++; $display("FAIL alu_bubble got=%h exp=0", ex_all()); end
        mem_valid = 1; mem_reg_write = 1; mem_mem_read = 0; mem_dest = 2; mem_data = 32'h1234;
        #1;
        checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL alu_stall2 got=%b exp=0", id_stall); end
        tick();
        checks++; if ({ex_valid, ex_dest, ex_pc, ex_rs_val, ex_rt_val} !== {1'b1, 5'd5, 32'h304, 32'h1234, 32'd7}) begin failures++; $display("FAIL alu_fwd got=%h exp=%h", {ex_valid, ex_dest, ex_pc, ex_rs_val, ex_rt_val}, {1'b1, 5'd5, 32'h304, 32'h1234, 32'd7}); end
        set_idle();
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        if_valid = 1; if_instr = i_type(6'h23, 5'd1, 5'd2, 16'h0); if_pc = 32'h400;
        tick();
        checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_dest} !== {3'b111, 5'd2}) begin failures++; $display("FAIL lw_prod got=%h exp=%h", {ex_valid, ex_reg_write, ex_mem_read, ex_dest}, {3'b111, 5'd2}); end
        if_instr = r_type(5'd2, 5'd2, 5'd3, 6'h20); if_pc = 32'h404;
        rf_data_1 = 32'hBAD1; rf_data_2 = 32'hBAD2;
        #1;
        checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL lw_stall1 got=%b exp=1", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL lw_bubble1 got=%b exp=0", ex_valid); end
        mem_valid = 1; mem_reg_write = 1; mem_mem_read = 1; mem_dest = 2; mem_data = 32'hF00;
        #1;
        checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL lw_stall2 got=%b exp=1", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL lw_bubble2 got=%b exp=0", ex_valid); end
        mem_valid = 0; mem_reg_write = 0; mem_mem_read = 0; mem_dest = 0;
        wb_valid = 1; wb_reg_write = 1; wb_dest = 2; wb_data = 32'hCAFE0001;
        #1;
        checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL lw_stall3 got=%b exp=0", id_stall); end
        tick();
        checks++; if ({ex_valid, ex_dest, ex_rs_val, ex_rt_val} !== {1'b1, 5'd3, 32'hCAFE0001, 32'hCAFE0001}) begin failures++; $display("FAIL lw_wb_fwd got=%h exp=%h", {ex_valid, ex_dest, ex_rs_val, ex_rt_val}, {1'b1, 5'd3, 32'hCAFE0001, 32'hCAFE0001}); end
        set_idle();
        tick();
    endtask

    task automatic test_priority_zero();
        set_idle();
        if_valid = 1; if_instr = r_type(5'd7, 5'd7, 5'd8, 6'h20);
        mem_valid = 1; mem_reg_write = 1; mem_dest = 7; mem_data = 32'h11;
        wb_valid = 1; wb_reg_write = 1; wb_dest = 7; wb_data = 32'h22;
        rf_data_1 = 32'h33; rf_data_2 = 32'h33;
        tick();
        checks++; if ({ex_rs_val, ex_rt_val} !== {32'h11, 32'h11}) begin failures++; $display("FAIL mem_over_wb got=%h exp=%h", {ex_rs_val, ex_rt_val}, {32'h11, 32'h11}); end
        set_idle();
        tick();
        if_valid = 1; if_instr = r_type(5'd0, 5'd0, 5'd9, 6'h20);
        mem_valid = 1; mem_reg_write = 1; mem_mem_read = 1; mem_dest = 0; mem_data = 32'h99;
        wb_valid = 1; wb_reg_write = 1; wb_dest = 0; wb_data = 32'h98;
        rf_data_1 = 32'h77; rf_data_2 = 32'h77;
        #1;
        checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL zero_stall got=%b exp=0", id_stall); end
        tick();
        checks++; if ({ex_valid, ex_rs_val, ex_rt_val} !== {1'b1, 64'd0}) begin failures++; $display("FAIL zero_val got=%h exp=%h", {ex_valid, ex_rs_val, ex_rt_val}, {1'b1, 64'd0}); end
        set_idle();
        tick();
    endtask

    task automatic test_flush_stall();
        set_idle();
        if_valid = 1; if_instr = r_type(5'd1, 5'd1, 5'd2, 6'h20);
        tick();
        if_instr = r_type(5'd2, 5'd1, 5'd5, 6'h22);
        flush = 1;
        #1;
        checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", id_stall); end
        tick();
        checks++; if (ex_all() !== '0) begin failures++; $display("FAIL flush_bubble got=%h exp=0", ex_all()); end
        set_idle();
        tick();
    endtask

    task automatic test_rst_mid_stall();
        set_idle();
        if_valid = 1; if_instr = r_type(5'd1, 5'd1, 5'd2, 6'h20);
        tick();
        if_instr = r_type(5'd2, 5'd1, 5'd5, 6'h22); if_pc = 32'h504;
        #1;
        checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL rst_stall_pre got=%b exp=1", id_stall); end
        #2 rst = 1;
        #1;
        checks++; if ({ex_all(), id_stall} !== '0) begin failures++; $display("FAIL rst_stall_clear got=%h exp=0", {ex_all(), id_stall}); end
        tick();
        rst = 0;
        #1;
        checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL rst_stall_post got=%b exp=0", id_stall); end
        tick();
        checks++; if ({ex_valid, ex_pc, ex_dest} !== {1'b1, 32'h504, 5'd5}) begin failures++; $display("FAIL rst_redecode got=%h exp=%h", {ex_valid, ex_pc, ex_dest}, {1'b1, 32'h504, 5'd5}); end
        set_idle();
        tick();
    endtask

    // Randomized run. The model keeps its own copy of the ID/EX latch and
    // derives every expectation from the decode, bypass and hazard rules.
    task automatic test_random();
        logic [5:0]  ops [0:11];
        logic        hold;
        logic        m_valid, m_rw, m_mr;
        logic [4:0]  m_dest;
        logic [31:0] m_pc, m_instr, m_rs, m_rt, m_imm;
        logic [5:0]  op;
        logic [4:0]  src [0:1];
        logic [31:0] rfv [0:1];
        logic        used [0:1];
        logic [31:0] val [0:1];
        logic        writes, haz, exp_stall, adv;
        logic [4:0]  dest;
        logic [167:0] exp_all;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h06, 6'h00};
        hold = 0;
        {m_valid, m_rw, m_mr, m_dest, m_pc, m_instr, m_rs, m_rt, m_imm} = '0;
        set_idle();
        tick();
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                if_valid = ($urandom_range(0, 4) != 0);
                if_instr = {ops[$urandom_range(0, 11)], 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3)), 16'($urandom)};
                if_instr[15:11] = 5'($urandom_range(0, 3));
                if_pc = $urandom;
            end
            flush = ($urandom_range(0, 7) == 0);
            rf_data_1 = $urandom; rf_data_2 = $urandom;
            mem_valid = $urandom_range(0, 1); mem_reg_write = $urandom_range(0, 1);
            mem_mem_read = $urandom_range(0, 1); mem_dest = 5'($urandom_range(0, 3));
            mem_data = $urandom;
            wb_valid = $urandom_range(0, 1); wb_reg_write = $urandom_range(0, 1);
            wb_dest = 5'($urandom_range(0, 3)); wb_data = $urandom;

            op = if_instr[31:26];
            src[0] = if_instr[25:21]; src[1] = if_instr[20:16];
            rfv[0] = rf_data_1;       rfv[1] = rf_data_2;
            used[0] = !(op inside {6'h02, 6'h03, 6'h0F});
            used[1] = (op inside {6'h00, 6'h04, 6'h05, 6'h2B});
            writes = (op inside {6'h00, 6'h03, [6'h08:6'h0F], 6'h23});
            dest = (op == 6'h00) ? if_instr[15:11] : (op == 6'h03) ? 5'd31 :
                   writes ? if_instr[20:16] : 5'd0;
            haz = 0;
            for (int s = 0; s < 2; s++) begin
                val[s] = rfv[s];
                if (used[s]) begin
                    if (src[s] == 0) val[s] = 0;
                    else if (mem_valid && mem_reg_write && mem_dest == src[s]) val[s] = mem_data;
                    else if (wb_valid && wb_reg_write && wb_dest == src[s]) val[s] = wb_data;
                    if (src[s] != 0 && m_valid && m_rw && m_dest == src[s]) haz = 1;
                    if (src[s] != 0 && mem_valid && mem_reg_write && mem_mem_read && mem_dest == src[s]) haz = 1;
                end
            end
            exp_stall = if_valid && !flush && haz;
            #1;
            checks++; if ({id_stall, rf_addr_1, rf_addr_2} !== {exp_stall, src[0], src[1]}) begin failures++; $display("FAIL rnd_comb[%0d] got=%h exp=%h", n, {id_stall, rf_addr_1, rf_addr_2}, {exp_stall, src[0], src[1]}); end
            adv = if_valid && !flush && !exp_stall;
            if (adv) begin
                m_valid = 1; m_rw = writes && dest != 0; m_mr = (op == 6'h23); m_dest = dest;
                m_pc = if_pc; m_instr = if_instr; m_rs = val[0]; m_rt = val[1];
                m_imm = 32'($signed(if_instr[15:0]));
            end else begin
                {m_valid, m_rw, m_mr, m_dest, m_pc, m_instr, m_rs, m_rt, m_imm} = '0;
            end
            tick();
            exp_all = {m_valid, m_rw, m_mr, m_pc, m_instr, m_rs, m_rt, m_imm, m_dest};
            checks++; if (ex_all() !== exp_all) begin failures++; $display("FAIL rnd_latch[%0d] got=%h exp=%h", n, ex_all(), exp_all); end
            hold = exp_stall;
        end
        set_idle();
        tick();
    endtask

    initial begin
        rst = 1;
        set_idle();
        test_reset();
        test_wb_bypass();
        test_alu_use();
        test_load_use();
        test_priority_zero();
        test_flush_stall();
        test_rst_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
